instr_issue_ctrl: RTL and testbench

- Multi-cycle issue/sequencing controller sitting directly behind the instruction decoder.
- Accepts one 32-bit ARM-format instruction per valid/ready handshake and classifies it by bits [27:26].
- Dispatches to the ALU, the iterative multiplier, the memory unit (req/ack) or the branch path.
- Enforces branch flush bubbles and memory timeouts, and counts retired instructions.

---
 rtl/instr_issue_ctrl_if.sv | 41 ++++
 rtl/instr_issue_ctrl.sv | 119 +++++++++++
 tb/tb_instr_issue_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_issue_ctrl_if
//  Purpose  : Decoder-to-issue handshake plus execution-unit strobes and status.
//  Revision : 1.0  initial release
// ============================================================================
interface instr_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic [31:0]      issued_instr;
    logic             alu_issue;
    logic             mul_start;
    logic             mem_req;
    logic             mem_is_load;
    logic             mem_ack;
    logic             mem_fault;
    logic             br_taken;
    logic             br_link;
    logic             undef_trap;
    logic             retire;
    logic [CNT_W-1:0] retire_count;
    logic             busy;

    modport slave (
        input  instr_valid, instr, mem_ack,
        output instr_ready, issued_instr, alu_issue, mul_start, mem_req,
               mem_is_load, mem_fault, br_taken, br_link, undef_trap,
               retire, retire_count, busy
    );

    modport master (
        output instr_valid, instr, mem_ack,
        input  instr_ready, issued_instr, alu_issue, mul_start, mem_req,
               mem_is_load, mem_fault, br_taken, br_link, undef_trap,
               retire, retire_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instr_issue_ctrl
//  Purpose  : Classifies one ARM instruction per handshake and sequences it
//             through ALU / multiplier / memory / branch with retire counting.
//  Revision : 1.0  initial release
// ============================================================================
module instr_issue_ctrl #(
    parameter int MUL_CYCLES   = 4,
    parameter int MEM_TIMEOUT  = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    instr_issue_ctrl_if.slave    bus
);
    localparam int c_max_a = (MUL_CYCLES > MEM_TIMEOUT) ? MUL_CYCLES : MEM_TIMEOUT;
    localparam int c_max   = (c_max_a > FLUSH_CYCLES) ? c_max_a : FLUSH_CYCLES;
    localparam int c_cw    = $clog2(c_max + 1);

    localparam logic [c_cw-1:0] c_mul_last   = c_cw'(MUL_CYCLES - 1);
    localparam logic [c_cw-1:0] c_mem_last   = c_cw'(MEM_TIMEOUT - 1);
    localparam logic [c_cw-1:0] c_flush_last = c_cw'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_alu   = 3'd1;
    localparam logic [2:0] c_st_mul   = 3'd2;
    localparam logic [2:0] c_st_mem   = 3'd3;
    localparam logic [2:0] c_st_br    = 3'd4;
    localparam logic [2:0] c_st_flush = 3'd5;
    localparam logic [2:0] c_st_undef = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [c_cw-1:0]  cnt_q, cnt_d;
    logic [31:0]      issued_q, issued_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic [2:0] w_class;
    logic       w_accept;
    logic       w_alu, w_mul, w_req, w_fault, w_br, w_undef, w_retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_st_idle;
            cnt_q        <= '0;
            issued_q     <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            issued_q     <= issued_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Condition 1111 is the unconditional space, which this core does not implement.
    always_comb begin
        w_class = c_st_alu;
        if (bus.instr[31:28] == 4'b1111) begin
            w_class = c_st_undef;
        end else begin
            case (bus.instr[27:26])
                2'b10:   w_class = c_st_br;
                2'b01:   w_class = c_st_mem;
                2'b11:   w_class = c_st_undef;
                default: w_class = (bus.instr[27:24] == 4'b0000 && bus.instr[7:4] == 4'b1001)
                                   ? c_st_mul : c_st_alu;
            endcase
        end
    end

    assign w_accept = bus.instr_valid && (state_q == c_st_idle);

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:  if (w_accept) state_d = w_class;
            c_st_alu:   state_d = c_st_idle;
            c_st_undef: state_d = c_st_idle;
            c_st_mul:   if (cnt_q == c_mul_last) state_d = c_st_idle;
            c_st_mem:   if (bus.mem_ack || cnt_q == c_mem_last) state_d = c_st_idle;
            c_st_br:    state_d = (FLUSH_CYCLES == 0) ? c_st_idle : c_st_flush;
            c_st_flush: if (cnt_q == c_flush_last) state_d = c_st_idle;
            default:    state_d = c_st_idle;
        endcase
        // Counter restarts at zero on every state entry and rests at zero in IDLE.
        cnt_d    = (state_q != c_st_idle && state_d == state_q) ? cnt_q + c_cw'(1) : '0;
        issued_d = w_accept ? bus.instr : issued_q;
    end

    always_comb begin
        w_alu    = (state_q == c_st_alu);
        w_mul    = (state_q == c_st_mul) && (cnt_q == '0);
        w_req    = (state_q == c_st_mem);
        w_fault  = w_req && !bus.mem_ack && (cnt_q == c_mem_last);
        w_br     = (state_q == c_st_br);
        w_undef  = (state_q == c_st_undef);
        w_retire = w_alu || w_br
                || ((state_q == c_st_mul) && (cnt_q == c_mul_last))
                || (w_req && bus.mem_ack);
        retire_cnt_d = w_retire ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
    end

    assign bus.instr_ready  = (state_q == c_st_idle);
    assign bus.busy         = (state_q != c_st_idle);
    assign bus.issued_instr = issued_q;
    assign bus.alu_issue    = w_alu;
    assign bus.mul_start    = w_mul;
    assign bus.mem_req      = w_req;
    assign bus.mem_is_load  = w_req && issued_q[20];
    assign bus.mem_fault    = w_fault;
    assign bus.br_taken     = w_br;
    assign bus.br_link      = w_br && issued_q[24];
    assign bus.undef_trap   = w_undef;
    assign bus.retire       = w_retire;
    assign bus.retire_count = retire_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_issue_ctrl
//  Purpose  : Directed vector table plus timing sequences for instr_issue_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_issue_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   exp_cnt;
    int   exp2;

    instr_issue_ctrl_if #(.CNT_W(16)) bus1 ();
    instr_issue_ctrl_if #(.CNT_W(4))  bus2 ();

    instr_issue_ctrl #(.MUL_CYCLES(4), .MEM_TIMEOUT(16), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );

    // Corner instance: single-cycle multiply, immediate timeout, no flush, narrow counter.
    instr_issue_ctrl #(.MUL_CYCLES(1), .MEM_TIMEOUT(1), .FLUSH_CYCLES(0), .CNT_W(4)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [8:0]  exp_out;   // {alu,mul,req,load,br,link,undef,retire,busy} one cycle after accept
        logic        is_mem;
        int          retires;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for instr_ready", name);
    endtask

    function automatic logic [8:0] outs1();
        return {bus1.alu_issue, bus1.mul_start, bus1.mem_req, bus1.mem_is_load,
                bus1.br_taken, bus1.br_link, bus1.undef_trap, bus1.retire, bus1.busy};
    endfunction

    // Called at a negedge; returns at the negedge of the first cycle after accept.
    task automatic send1(input logic [31:0] w);
        int n;
        n = 0;
        bus1.instr       = w;
        bus1.instr_valid = 1'b1;
        while (!bus1.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus1.instr_ready) timeout_fail("send1");
        @(posedge clk);
        @(negedge clk);
        bus1.instr_valid = 1'b0;
    endtask

    task automatic send2(input logic [31:0] w);
        int n;
        n = 0;
        bus2.instr       = w;
        bus2.instr_valid = 1'b1;
        while (!bus2.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus2.instr_ready) timeout_fail("send2");
        @(posedge clk);
        @(negedge clk);
        bus2.instr_valid = 1'b0;
    endtask

    task automatic wait_idle1(input string name);
        int n;
        n = 0;
        while (!bus1.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus1.instr_ready) timeout_fail(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; exp_cnt = 0; exp2 = 0;
        vecs[0]  = '{32'hE0812003, 9'b100000011, 1'b0, 1};  // ADD
        vecs[1]  = '{32'hE3A00005, 9'b100000011, 1'b0, 1};  // MOV imm
        vecs[2]  = '{32'hE1000291, 9'b100000011, 1'b0, 1};  // [27:24]!=0 stays ALU
        vecs[3]  = '{32'hE0000291, 9'b010000001, 1'b0, 1};  // MUL
        vecs[4]  = '{32'h00000291, 9'b010000001, 1'b0, 1};  // MUL, cond EQ
        vecs[5]  = '{32'hE5912000, 9'b001100001, 1'b1, 1};  // LDR
        vecs[6]  = '{32'hE5812000, 9'b001000001, 1'b1, 1};  // STR
        vecs[7]  = '{32'hEA000000, 9'b000010011, 1'b0, 1};  // B
        vecs[8]  = '{32'hEB000010, 9'b000011011, 1'b0, 1};  // BL
        vecs[9]  = '{32'hF0000000, 9'b000000101, 1'b0, 0};  // cond 1111
        vecs[10] = '{32'hEC000000, 9'b000000101, 1'b0, 0};  // class 11
        vecs[11] = '{32'hFA000000, 9'b000000101, 1'b0, 0};  // branch with cond 1111

        rst = 1'b1;
        bus1.instr_valid = 1'b0; bus1.instr = '0; bus1.mem_ack = 1'b0;
        bus2.instr_valid = 1'b0; bus2.instr = '0; bus2.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs",   {23'd0, outs1()}, 32'd0);
        chk("reset_ready",  bus1.instr_ready, 1);
        chk("reset_issued", bus1.issued_instr, 0);
        chk("reset_count",  bus1.retire_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single ALU op timing
        send1(32'hE0812003);
        chk("alu_pulse", {bus1.alu_issue, bus1.retire, bus1.instr_ready}, 3'b110);
        chk("alu_issued", bus1.issued_instr, 32'hE0812003);
        @(negedge clk);
        exp_cnt = 1;
        chk("alu_ready_back", {bus1.instr_ready, bus1.alu_issue}, 2'b10);
        chk("alu_count", bus1.retire_count, exp_cnt);

        // Classification table
        for (int i = 0; i < 12; i++) begin
            send1(vecs[i].instr);
            chk($sformatf("vec%0d_outs", i), {23'd0, outs1()}, {23'd0, vecs[i].exp_out});
            if (vecs[i].is_mem) bus1.mem_ack = 1'b1;
            @(negedge clk);
            wait_idle1($sformatf("vec%0d_idle", i));
            bus1.mem_ack = 1'b0;
            exp_cnt += vecs[i].retires;
            chk($sformatf("vec%0d_count", i), bus1.retire_count, exp_cnt);
        end

        // MUL occupancy: start at N+1, retire at N+4
        send1(32'hE0000291);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("mul_c%0d", i),
                {bus1.mul_start, bus1.retire, bus1.instr_ready, bus1.busy},
                {(i == 1), (i == 4), 1'b0, 1'b1});
            @(negedge clk);
        end
        exp_cnt++;
        chk("mul_done", {bus1.instr_ready, bus1.busy}, 2'b10);
        chk("mul_count", bus1.retire_count, exp_cnt);

        // Load acked in its fourth request cycle
        send1(32'hE5912000);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("ld_wait%0d", i), {bus1.mem_req, bus1.mem_is_load, bus1.retire}, 3'b110);
            @(negedge clk);
        end
        bus1.mem_ack = 1'b1;
        #1;
        chk("ld_ack", {bus1.mem_req, bus1.mem_is_load, bus1.retire, bus1.mem_fault}, 4'b1110);
        @(negedge clk);
        bus1.mem_ack = 1'b0;
        exp_cnt++;
        chk("ld_release", {bus1.mem_req, bus1.instr_ready}, 2'b01);
        chk("ld_count", bus1.retire_count, exp_cnt);

        // Load never acked: fault in the 16th request cycle
        send1(32'hE5912000);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("to_c%0d", i), {bus1.mem_req, bus1.mem_fault, bus1.retire},
                {1'b1, (i == 16), 1'b0});
            @(negedge clk);
        end
        chk("to_release", {bus1.mem_req, bus1.mem_fault, bus1.instr_ready}, 3'b001);
        chk("to_count", bus1.retire_count, exp_cnt);

        // Ack coincident with timeout: ack wins
        send1(32'hE5812000);
        repeat (15) @(negedge clk);
        bus1.mem_ack = 1'b1;
        #1;
        chk("tie_ack", {bus1.mem_req, bus1.mem_fault, bus1.retire}, 3'b101);
        @(negedge clk);
        bus1.mem_ack = 1'b0;
        exp_cnt++;
        chk("tie_count", bus1.retire_count, exp_cnt);

        // BL followed by an instruction held valid through the flush
        send1(32'hEB000010);
        chk("bl_pulse", {bus1.br_taken, bus1.br_link, bus1.retire}, 3'b111);
        bus1.instr = 32'hE0812003;
        bus1.instr_valid = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("flush_ready_n%0d", i), bus1.instr_ready, (i == 4));
        end
        @(negedge clk);
        bus1.instr_valid = 1'b0;
        chk("post_flush_alu", {bus1.alu_issue, bus1.br_taken}, 2'b10);
        @(negedge clk);
        exp_cnt += 2;
        chk("flush_count", bus1.retire_count, exp_cnt);

        // Stray ack in IDLE
        bus1.mem_ack = 1'b1;
        #1;
        chk("stray_ack", {bus1.retire, bus1.mem_fault, bus1.busy}, 3'b000);
        @(negedge clk);
        bus1.mem_ack = 1'b0;
        chk("stray_count", bus1.retire_count, exp_cnt);

        // Reset during a memory wait
        send1(32'hE5912000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {bus1.mem_req, bus1.busy, bus1.mem_fault, bus1.retire, bus1.instr_ready}, 5'b00001);
        chk("rst_count", bus1.retire_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Corner instance: MUL_CYCLES=1, FLUSH_CYCLES=0, MEM_TIMEOUT=1
        send2(32'hE0000291);
        chk("m1_pulse", {bus2.mul_start, bus2.retire, bus2.busy}, 3'b111);
        @(negedge clk);
        chk("m1_ready", bus2.instr_ready, 1);
        send2(32'hEA000000);
        chk("f0_pulse", {bus2.br_taken, bus2.retire}, 2'b11);
        @(negedge clk);
        chk("f0_ready", bus2.instr_ready, 1);
        send2(32'hE5912000);
        chk("t1_fault", {bus2.mem_req, bus2.mem_fault, bus2.retire}, 3'b110);
        @(negedge clk);
        chk("t1_release", {bus2.mem_req, bus2.instr_ready}, 2'b01);
        exp2 = 2;
        chk("w_start", bus2.retire_count, exp2);
        for (int i = 0; i < 14; i++) begin
            send2(32'hE0812003);
            @(negedge clk);
            exp2 = (exp2 + 1) % 16;
            chk($sformatf("w_step%0d", i), bus2.retire_count, exp2);
        end
        chk("wrap_zero", bus2.retire_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
